// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared constants for the two-requester memory arbiter. This holds the FSM
// state encodings, the Grant_o encodings and the encoding of the "last
// served" flag.
// The state encodings match the Grant_o encodings, so the registered grant
// output is just the next state.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_GNT_I = 2'b01,
        ARB_GNT_D = 2'b10
    } arb_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    // Maps an arbiter state to the value shown on Grant_o.
    function automatic logic [1:0] grantOf(arb_state_e s);
        case (s)
            ARB_GNT_I: grantOf = GRANT_I;
            ARB_GNT_D: grantOf = GRANT_D;
            default:   grantOf = GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Combinational winner select for the memory arbiter. It takes the two
// request enables and the "last served" flag, and returns the state the
// arbiter should enter from IDLE.
// Ports:
//   i_iReq  - icache request enable
//   i_dReq  - dcache request enable
//   i_last  - last requester served (LAST_I / LAST_D)
//   o_pick  - ARB_GNT_I, ARB_GNT_D, or ARB_IDLE when nobody is asking
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       i_iReq,
    input  logic       i_dReq,
    input  logic       i_last,
    output arb_state_e o_pick
);

    // On a tie, the requester that was not served last wins. Because last
    // resets to LAST_I, the dcache wins the first tie after reset.
    always_comb begin
        o_pick = ARB_IDLE;
        if (i_iReq && i_dReq) begin
            o_pick = (i_last == LAST_I) ? ARB_GNT_D : ARB_GNT_I;
        end else if (i_iReq) begin
            o_pick = ARB_GNT_I;
        end else if (i_dReq) begin
            o_pick = ARB_GNT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single line-wide memory port between the icache and dcache
// controllers. Only one transaction is outstanding at a time, and priority
// alternates when both controllers request together.
// Ports:
//   Clk_i, Rst_i         - clock, synchronous active-high reset
//   IMem*_i / IMem*_o    - icache request side (enable, write, addr, data in;
//                          data out, ack out)
//   DMem*_i / DMem*_o    - dcache request side, same shape
//   MemData_i, MemAck_i  - memory read data and completion pulse
//   MemData_o, MemAddr_o - write data and address to memory
//   MemEnable_o          - registered memory request
//   MemWrite_o           - memory write flag
//   Grant_o              - registered current owner (00 idle, 01 I, 10 D)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              Clk_i,
    input  logic              Rst_i,

    input  logic              IMemEnable_i,
    input  logic              IMemWrite_i,
    input  logic [ADDR_W-1:0] IMemAddr_i,
    input  logic [LINE_W-1:0] IMemData_i,
    output logic [LINE_W-1:0] IMemData_o,
    output logic              IMemAck_o,

    input  logic              DMemEnable_i,
    input  logic              DMemWrite_i,
    input  logic [ADDR_W-1:0] DMemAddr_i,
    input  logic [LINE_W-1:0] DMemData_i,
    output logic [LINE_W-1:0] DMemData_o,
    output logic              DMemAck_o,

    input  logic [LINE_W-1:0] MemData_i,
    input  logic              MemAck_i,
    output logic [LINE_W-1:0] MemData_o,
    output logic [ADDR_W-1:0] MemAddr_o,
    output logic              MemEnable_o,
    output logic              MemWrite_o,

    output logic [1:0]        Grant_o
);

    arb_state_e r_state;
    logic       r_last;
    logic       r_memEnable;
    logic [1:0] r_grant;
    arb_state_e w_pick;
    logic       w_ownI;
    logic       w_ownD;

    mem_arb_pick u_pick (
        .i_iReq (IMemEnable_i),
        .i_dReq (DMemEnable_i),
        .i_last (r_last),
        .o_pick (w_pick)
    );

    // Arbitration FSM. MemEnable_o and Grant_o are registered alongside the
    // state, so neither has a combinational path from the request or ack
    // inputs. After an ack the FSM always passes through IDLE before it
    // re-arbitrates. This gives the old owner a cycle to drop its enable.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_state     <= ARB_IDLE;
            r_last      <= LAST_I;
            r_memEnable <= 1'b0;
            r_grant     <= GRANT_NONE;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_state     <= w_pick;
                    r_memEnable <= (w_pick != ARB_IDLE);
                    r_grant     <= grantOf(w_pick);
                end
                ARB_GNT_I: begin
                    if (MemAck_i) begin
                        r_state     <= ARB_IDLE;
                        r_last      <= LAST_I;
                        r_memEnable <= 1'b0;
                        r_grant     <= GRANT_NONE;
                    end
                end
                ARB_GNT_D: begin
                    if (MemAck_i) begin
                        r_state     <= ARB_IDLE;
                        r_last      <= LAST_D;
                        r_memEnable <= 1'b0;
                        r_grant     <= GRANT_NONE;
                    end
                end
                default: begin
                    r_state     <= ARB_IDLE;
                    r_memEnable <= 1'b0;
                    r_grant     <= GRANT_NONE;
                end
            endcase
        end
    end

    assign w_ownI = (r_state == ARB_GNT_I);
    assign w_ownD = (r_state == ARB_GNT_D);

    // The address, data and write flag come straight from the owner. The
    // owner holds them stable for the whole grant. In IDLE they are forced
    // to zero.
    assign MemAddr_o   = w_ownI ? IMemAddr_i  : (w_ownD ? DMemAddr_i  : '0);
    assign MemData_o   = w_ownI ? IMemData_i  : (w_ownD ? DMemData_i  : '0);
    assign MemWrite_o  = w_ownI ? IMemWrite_i : (w_ownD ? DMemWrite_i : 1'b0);
    assign MemEnable_o = r_memEnable;
    assign Grant_o     = r_grant;

    // Acks are the only same-cycle paths from MemAck_i. An ack that arrives
    // in IDLE reaches neither requester.
    assign IMemAck_o = MemAck_i && w_ownI;
    assign DMemAck_o = MemAck_i && w_ownD;

    // Read data goes to both requesters. Each one qualifies it with its own
    // ack.
    assign IMemData_o = MemData_i;
    assign DMemData_o = MemData_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter. Inputs change 1 time unit
// after the rising edge. Outputs are sampled after that settle delay.
module tb_mem_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              Clk_i;
    logic              Rst_i;
    logic              IMemEnable_i;
    logic              IMemWrite_i;
    logic [ADDR_W-1:0] IMemAddr_i;
    logic [LINE_W-1:0] IMemData_i;
    logic [LINE_W-1:0] IMemData_o;
    logic              IMemAck_o;
    logic              DMemEnable_i;
    logic              DMemWrite_i;
    logic [ADDR_W-1:0] DMemAddr_i;
    logic [LINE_W-1:0] DMemData_i;
    logic [LINE_W-1:0] DMemData_o;
    logic              DMemAck_o;
    logic [LINE_W-1:0] MemData_i;
    logic              MemAck_i;
    logic [LINE_W-1:0] MemData_o;
    logic [ADDR_W-1:0] MemAddr_o;
    logic              MemEnable_o;
    logic              MemWrite_o;
    logic [1:0]        Grant_o;

    int checkCount;
    int passCount;

    logic [LINE_W-1:0] patA5;
    logic [LINE_W-1:0] pat1234;
    logic [LINE_W-1:0] patIData;
    logic [1:0]        expGrants [6];

    mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .Clk_i        (Clk_i),
        .Rst_i        (Rst_i),
        .IMemEnable_i (IMemEnable_i),
        .IMemWrite_i  (IMemWrite_i),
        .IMemAddr_i   (IMemAddr_i),
        .IMemData_i   (IMemData_i),
        .IMemData_o   (IMemData_o),
        .IMemAck_o    (IMemAck_o),
        .DMemEnable_i (DMemEnable_i),
        .DMemWrite_i  (DMemWrite_i),
        .DMemAddr_i   (DMemAddr_i),
        .DMemData_i   (DMemData_i),
        .DMemData_o   (DMemData_o),
        .DMemAck_o    (DMemAck_o),
        .MemData_i    (MemData_i),
        .MemAck_i     (MemAck_i),
        .MemData_o    (MemData_o),
        .MemAddr_o    (MemAddr_o),
        .MemEnable_o  (MemEnable_o),
        .MemWrite_o   (MemWrite_o),
        .Grant_o      (Grant_o)
    );

    // 10-unit clock period.
    initial Clk_i = 1'b0;
    always #5 Clk_i = ~Clk_i;

    // Compares one observed value with its hand-computed expectation and
    // keeps the running totals.
    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                               input logic [LINE_W-1:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Advances to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge Clk_i);
        #1;
    endtask

    // Drives the two enables and the memory ack, then lets the
    // combinational outputs settle.
    task automatic applyStimulus(input logic iEn, input logic dEn, input logic ack);
        IMemEnable_i = iEn;
        DMemEnable_i = dEn;
        MemAck_i     = ack;
        #1;
    endtask

    // Holds reset for two cycles. Leaves all requests idle.
    task automatic doReset();
        Rst_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        Rst_i = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        patA5      = {32{8'hA5}};
        pat1234    = {16{16'h1234}};
        patIData   = {8{32'hCAFE_0001}};
        expGrants  = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};

        Rst_i       = 1'b0;
        IMemWrite_i = 1'b0;
        IMemAddr_i  = 32'h0000_1000;
        IMemData_i  = patIData;
        DMemWrite_i = 1'b0;
        DMemAddr_i  = 32'h0000_0400;
        DMemData_i  = '0;
        MemData_i   = {8{32'h0BAD_F00D}};
        MemAck_i    = 1'b0;
        IMemEnable_i = 1'b0;
        DMemEnable_i = 1'b0;

        $display("[TB] start");

        // Reset values. The data outputs follow MemData_i.
        doReset();
        checkOutput("rst_grant",   Grant_o,     2'b00);
        checkOutput("rst_enable",  MemEnable_o, 1'b0);
        checkOutput("rst_addr",    MemAddr_o,   '0);
        checkOutput("rst_write",   MemWrite_o,  1'b0);
        checkOutput("rst_iack",    IMemAck_o,   1'b0);
        checkOutput("rst_dack",    DMemAck_o,   1'b0);
        checkOutput("rst_idata",   IMemData_o,  {8{32'h0BAD_F00D}});

        // Single dcache read. Memory acks 10 cycles into the grant.
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("rd_grant",  Grant_o,     2'b10);
        checkOutput("rd_enable", MemEnable_o, 1'b1);
        checkOutput("rd_addr",   MemAddr_o,   32'h0000_0400);
        for (int i = 0; i < 9; i++) begin
            tick();
            checkOutput("rd_dack_wait", DMemAck_o, 1'b0);
        end
        MemData_i = patA5;
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("rd_dack",  DMemAck_o,  1'b1);
        checkOutput("rd_iack",  IMemAck_o,  1'b0);
        checkOutput("rd_ddata", DMemData_o, patA5);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rd_dack_off", DMemAck_o,   1'b0);
        checkOutput("rd_idle",     Grant_o,     2'b00);
        checkOutput("rd_en_off",   MemEnable_o, 1'b0);

        // Simultaneous requests from reset: D wins first, then I.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("tie_first", Grant_o, 2'b10);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("tie_dack", DMemAck_o, 1'b1);
        checkOutput("tie_iack_quiet", IMemAck_o, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("tie_idle", Grant_o, 2'b00);
        tick();
        checkOutput("tie_second", Grant_o, 2'b01);
        checkOutput("tie_iaddr",  MemAddr_o, 32'h0000_1000);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("tie_iack", IMemAck_o, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Both requesters saturating for six transactions. The enables stay
        // high, and exactly one idle cycle separates transactions.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 6; n++) begin
            tick();
            checkOutput("sat_grant", Grant_o, expGrants[n]);
            tick();
            applyStimulus(1'b1, 1'b1, 1'b1);
            checkOutput("sat_iack", IMemAck_o, expGrants[n] == 2'b01);
            checkOutput("sat_dack", DMemAck_o, expGrants[n] == 2'b10);
            tick();
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkOutput("sat_idle", Grant_o, 2'b00);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();

        // Write pass-through on the D port.
        doReset();
        DMemWrite_i = 1'b1;
        DMemData_i  = pat1234;
        DMemAddr_i  = 32'h0000_0080;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("wr_pre_write", MemWrite_o, 1'b0);
        checkOutput("wr_pre_data",  MemData_o,  '0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("wr_write", MemWrite_o, 1'b1);
            checkOutput("wr_data",  MemData_o,  pat1234);
            checkOutput("wr_addr",  MemAddr_o,  32'h0000_0080);
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("wr_dack", DMemAck_o, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("wr_post_write", MemWrite_o, 1'b0);
        checkOutput("wr_post_data",  MemData_o,  '0);
        checkOutput("wr_post_addr",  MemAddr_o,  '0);
        DMemWrite_i = 1'b0;

        // Spurious ack in IDLE. It must not disturb last, which is D after
        // the write, so a following tie must still go to I.
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("sp_iack", IMemAck_o, 1'b0);
        checkOutput("sp_dack", DMemAck_o, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("sp_grant", Grant_o, 2'b00);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("sp_tie_after", Grant_o, 2'b01);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);

        // I-only request after a spurious ack is granted normally.
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("sp_i_grant", Grant_o, 2'b01);
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);

        // The D requester drops its enable early. The ack is still delivered.
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("drop_hold", Grant_o, 2'b10);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("drop_dack", DMemAck_o, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("drop_idle", Grant_o, 2'b00);

        // Reset in the middle of a D transaction. A late ack is ignored.
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("mr_granted", Grant_o, 2'b10);
        Rst_i = 1'b1;
        tick();
        Rst_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("mr_enable", MemEnable_o, 1'b0);
        checkOutput("mr_grant",  Grant_o,     2'b00);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("mr_late_dack", DMemAck_o, 1'b0);
        checkOutput("mr_late_iack", IMemAck_o, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("mr_stay_idle", Grant_o, 2'b00);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
